// File: rtl/mutex_merge_pkg.sv
// Shared types and constants for the clocked N-port mutex merge.
package mutex_merge_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Ceiling log2, used to size the round-robin pointer and port index.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mutex_merge_n_sync_arbiter.sv
// merge_arbiter: combinational pick of one pending port.
//   i_pending : request vector (registered upstream)
//   i_ptr     : round-robin start index (ignored in fixed mode)
//   o_gnt_c   : one-hot winner, 0 when nothing pending
//   o_idx_c   : encoded winner index
//   o_valid_c : any request present
module merge_arbiter
  import mutex_merge_pkg::*;
#(
  parameter int unsigned NUM_PORTS = 4,
  parameter int unsigned ARB_MODE  = 0,
  parameter int unsigned PTR_W     = 2
) (
  input  logic [NUM_PORTS-1:0] i_pending,
  input  logic [PTR_W-1:0]     i_ptr,
  output logic [NUM_PORTS-1:0] o_gnt_c,
  output logic [PTR_W-1:0]     o_idx_c,
  output logic                 o_valid_c
);

  // Scan NUM_PORTS candidates starting at 0 (fixed) or i_ptr (rr), first hit wins.
  always_comb begin
    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_cand;
    logic             w_found;
    o_gnt_c   = '0;
    o_idx_c   = '0;
    o_valid_c = 1'b0;
    w_found   = 1'b0;
    w_sum     = '0;
    w_cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (ARB_MODE == ARB_RR) begin
        // ptr < NUM_PORTS and k < NUM_PORTS, so one subtraction wraps.
        w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
        if (w_sum >= (PTR_W+1)'(NUM_PORTS)) begin
          w_sum = w_sum - (PTR_W+1)'(NUM_PORTS);
        end
      end else begin
        w_sum = (PTR_W+1)'(k);
      end
      w_cand = w_sum[PTR_W-1:0];
      if (!w_found && i_pending[w_cand]) begin
        w_found          = 1'b1;
        o_gnt_c[w_cand]  = 1'b1;
        o_idx_c          = w_cand;
      end
    end
    o_valid_c = w_found;
  end

endmodule

// File: rtl/mutex_merge_n_sync.sv
// Clocked N-port drive/free merge with one outstanding downstream transaction.
//   clk, rst     : clock, synchronous active-high reset
//   i_drive      : per-port one-cycle request pulses
//   i_data       : per-port payloads, port p at [p*DATA_WIDTH +: DATA_WIDTH]
//   o_free       : per-port one-cycle completion pulses
//   o_driveNext  : downstream one-cycle request pulse
//   o_data       : downstream payload
//   i_freeNext   : downstream one-cycle completion pulse
//   o_grant      : one-hot owner of outstanding transaction
//   o_pending    : captured-but-not-freed ports
//   o_err        : sticky protocol violation
module mutex_merge_n_sync
  import mutex_merge_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned ARB_MODE   = 0
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            i_drive,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_data,
  output logic [NUM_PORTS-1:0]            o_free,
  output logic                            o_driveNext,
  output logic [DATA_WIDTH-1:0]           o_data,
  input  logic                            i_freeNext,
  output logic [NUM_PORTS-1:0]            o_grant,
  output logic [NUM_PORTS-1:0]            o_pending,
  output logic                            o_err
);

  localparam int unsigned PTR_W = clog2(NUM_PORTS);

  state_t                  r_state;
  logic [NUM_PORTS-1:0]    r_pending;
  logic [NUM_PORTS-1:0]    r_grant;
  logic [NUM_PORTS-1:0]    r_free;
  logic                    r_drive_next;
  logic [DATA_WIDTH-1:0]   r_data;
  logic                    r_err;
  logic [PTR_W-1:0]        r_ptr;
  logic [PTR_W-1:0]        r_gidx;
  logic [DATA_WIDTH-1:0]   r_hold [NUM_PORTS];

  logic [NUM_PORTS-1:0]    w_gnt;
  logic [PTR_W-1:0]        w_idx;
  logic                    w_valid;
  logic [NUM_PORTS-1:0]    w_set;
  logic [NUM_PORTS-1:0]    w_clr;
  logic                    w_drive_err;
  logic [PTR_W:0]          w_ptr_sum;
  logic [PTR_W-1:0]        w_ptr_inc;

  merge_arbiter #(
    .NUM_PORTS (NUM_PORTS),
    .ARB_MODE  (ARB_MODE),
    .PTR_W     (PTR_W)
  ) u_arb (
    .i_pending (r_pending),
    .i_ptr     (r_ptr),
    .o_gnt_c   (w_gnt),
    .o_idx_c   (w_idx),
    .o_valid_c (w_valid)
  );

  // Capture only into empty slots; a pulse on an occupied slot is a protocol error.
  assign w_set       = i_drive & ~r_pending;
  assign w_drive_err = |(i_drive & r_pending);
  assign w_clr       = ((r_state == WAIT) && i_freeNext) ? r_grant : '0;

  // Pointer moves to the port after the one just completed, wrapping.
  assign w_ptr_sum = {1'b0, r_gidx} + (PTR_W+1)'(1);
  assign w_ptr_inc = (w_ptr_sum == (PTR_W+1)'(NUM_PORTS)) ? '0 : w_ptr_sum[PTR_W-1:0];

  // Payload holding registers; contents are don't-care until pending is set.
  always_ff @(posedge clk) begin
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (!rst && w_set[p]) begin
        r_hold[p] <= i_data[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Pending, FSM, pointer and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pending    <= '0;
      r_grant      <= '0;
      r_free       <= '0;
      r_drive_next <= 1'b0;
      r_data       <= '0;
      r_err        <= 1'b0;
      r_ptr        <= '0;
      r_gidx       <= '0;
    end else begin
      r_free       <= '0;
      r_drive_next <= 1'b0;
      r_pending    <= (r_pending & ~w_clr) | w_set;
      if (w_drive_err) begin
        r_err <= 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (i_freeNext) begin
            r_err <= 1'b1;
          end
          if (w_valid) begin
            r_grant      <= w_gnt;
            r_gidx       <= w_idx;
            r_data       <= r_hold[w_idx];
            r_drive_next <= 1'b1;
            r_state      <= WAIT;
          end
        end
        WAIT: begin
          if (i_freeNext) begin
            r_free  <= r_grant;
            r_grant <= '0;
            r_state <= IDLE;
            if (ARB_MODE == ARB_RR) begin
              r_ptr <= w_ptr_inc;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_free      = r_free;
  assign o_driveNext = r_drive_next;
  assign o_data      = r_data;
  assign o_grant     = r_grant;
  assign o_pending   = r_pending;
  assign o_err       = r_err;

endmodule

// File: tb/tb_mutex_merge_n_sync.sv
// Directed bench: fixed-priority instance (with optional zero-latency consumer)
// and a round-robin instance, 4 ports x 16-bit payload.
module tb_mutex_merge_n_sync;

  localparam int unsigned NP = 4;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Fixed-priority instance
  logic              f_rst, f_free_tb, f_zl, f_fnext;
  logic [NP-1:0]     f_drive, f_free, f_grant, f_pend;
  logic [NP*DW-1:0]  f_data;
  logic [DW-1:0]     f_odata;
  logic              f_dn, f_err;
  assign f_fnext = f_zl ? f_dn : f_free_tb;

  mutex_merge_n_sync #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(0)) u_fix (
    .clk(clk), .rst(f_rst), .i_drive(f_drive), .i_data(f_data), .o_free(f_free),
    .o_driveNext(f_dn), .o_data(f_odata), .i_freeNext(f_fnext), .o_grant(f_grant),
    .o_pending(f_pend), .o_err(f_err)
  );

  // Round-robin instance
  logic              r_rst, r_fnext;
  logic [NP-1:0]     r_drive, r_free, r_grant, r_pend;
  logic [NP*DW-1:0]  r_data;
  logic [DW-1:0]     r_odata;
  logic              r_dn, r_err;

  mutex_merge_n_sync #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .ARB_MODE(1)) u_rr (
    .clk(clk), .rst(r_rst), .i_drive(r_drive), .i_data(r_data), .o_free(r_free),
    .o_driveNext(r_dn), .o_data(r_odata), .i_freeNext(r_fnext), .o_grant(r_grant),
    .o_pending(r_pend), .o_err(r_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0]  ord_g [3];
    logic [15:0] ord_d [3];
    logic [3:0]  ord_p [3];
    logic [3:0]  eg;

    f_rst = 1'b1; f_drive = '0; f_data = '0; f_free_tb = 1'b0; f_zl = 1'b0;
    r_rst = 1'b1; r_drive = '0; r_data = '0; r_fnext = 1'b0;
    tick(); tick();
    f_rst = 1'b0; r_rst = 1'b0;

    // Reset state
    chk("rst_grant", 64'(f_grant), 64'h0);
    chk("rst_pend",  64'(f_pend),  64'h0);
    chk("rst_dn",    64'(f_dn),    64'h0);
    chk("rst_free",  64'(f_free),  64'h0);
    chk("rst_data",  64'(f_odata), 64'h0);
    chk("rst_err",   64'(f_err),   64'h0);

    // Single request on port 2
    f_drive = 4'b0100; f_data[2*DW +: DW] = 16'h00A5;
    tick();
    f_drive = '0; f_data = '0;
    chk("sgl_pend", 64'(f_pend), 64'h4);
    chk("sgl_dn0",  64'(f_dn),   64'h0);
    tick();
    chk("sgl_dn1",   64'(f_dn),    64'h1);
    chk("sgl_grant", 64'(f_grant), 64'h4);
    chk("sgl_data",  64'(f_odata), 64'hA5);
    tick();
    chk("sgl_dn_fall", 64'(f_dn),    64'h0);
    chk("sgl_gstable", 64'(f_grant), 64'h4);
    tick();
    f_free_tb = 1'b1;
    tick();
    f_free_tb = 1'b0;
    chk("sgl_free",  64'(f_free),  64'h4);
    chk("sgl_gclr",  64'(f_grant), 64'h0);
    chk("sgl_pclr",  64'(f_pend),  64'h0);
    chk("sgl_dhold", 64'(f_odata), 64'hA5);
    tick();
    chk("sgl_free_end", 64'(f_free), 64'h0);
    chk("sgl_err",      64'(f_err),  64'h0);

    // Simultaneous requests on ports 0,1,3, fixed priority
    f_drive = 4'b1011;
    f_data[0*DW +: DW] = 16'h1000;
    f_data[1*DW +: DW] = 16'h1111;
    f_data[3*DW +: DW] = 16'h3333;
    tick();
    f_drive = '0; f_data = '0;
    chk("fix_pend", 64'(f_pend), 64'hB);
    ord_g[0] = 4'b0001; ord_d[0] = 16'h1000; ord_p[0] = 4'b1010;
    ord_g[1] = 4'b0010; ord_d[1] = 16'h1111; ord_p[1] = 4'b1000;
    ord_g[2] = 4'b1000; ord_d[2] = 16'h3333; ord_p[2] = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("fix_grant", 64'(f_grant), 64'(ord_g[i]));
      chk("fix_data",  64'(f_odata), 64'(ord_d[i]));
      chk("fix_dn",    64'(f_dn),    64'h1);
      f_free_tb = 1'b1;
      tick();
      f_free_tb = 1'b0;
      chk("fix_free", 64'(f_free), 64'(ord_g[i]));
      chk("fix_pend", 64'(f_pend), 64'(ord_p[i]));
    end
    chk("fix_err", 64'(f_err), 64'h0);

    // Zero-latency consumer: one transaction every 2 cycles
    f_zl = 1'b1;
    f_drive = 4'b1001;
    f_data[0*DW +: DW] = 16'h0F0F;
    f_data[3*DW +: DW] = 16'hF0F0;
    tick();
    f_drive = '0; f_data = '0;
    tick();
    chk("zl_g0",  64'(f_grant), 64'h1);
    chk("zl_d0",  64'(f_odata), 64'h0F0F);
    tick();
    chk("zl_f0",  64'(f_free),  64'h1);
    chk("zl_gc",  64'(f_grant), 64'h0);
    tick();
    chk("zl_g3",  64'(f_grant), 64'h8);
    chk("zl_d3",  64'(f_odata), 64'hF0F0);
    chk("zl_dn",  64'(f_dn),    64'h1);
    tick();
    chk("zl_f3",  64'(f_free),  64'h8);
    chk("zl_pend",64'(f_pend),  64'h0);
    chk("zl_err", 64'(f_err),   64'h0);
    f_zl = 1'b0;
    tick();

    // Drive while pending: second pulse ignored, error set
    f_drive = 4'b0010; f_data[1*DW +: DW] = 16'h2222;
    tick();
    f_drive = '0; f_data = '0;
    chk("dup_err0", 64'(f_err), 64'h0);
    tick();
    chk("dup_grant", 64'(f_grant), 64'h2);
    f_drive = 4'b0010; f_data[1*DW +: DW] = 16'hDEAD;
    tick();
    f_drive = '0; f_data = '0;
    chk("dup_err1", 64'(f_err),   64'h1);
    chk("dup_pend", 64'(f_pend),  64'h2);
    chk("dup_data", 64'(f_odata), 64'h2222);
    f_free_tb = 1'b1;
    tick();
    f_free_tb = 1'b0;
    chk("dup_free", 64'(f_free), 64'h2);
    tick();
    chk("dup_nore", 64'(f_grant), 64'h0);

    // Stray freeNext while idle
    f_rst = 1'b1;
    tick();
    f_rst = 1'b0;
    chk("stray_err0", 64'(f_err), 64'h0);
    f_free_tb = 1'b1;
    tick();
    f_free_tb = 1'b0;
    chk("stray_err1", 64'(f_err),  64'h1);
    chk("stray_free", 64'(f_free), 64'h0);

    // Mid-transaction reset
    f_rst = 1'b1;
    tick();
    f_rst = 1'b0;
    f_drive = 4'b0111;
    tick();
    f_drive = '0;
    tick();
    chk("mid_grant", 64'(f_grant), 64'h1);
    f_rst = 1'b1; f_drive = 4'b0001; f_free_tb = 1'b1;
    tick();
    f_rst = 1'b0; f_drive = '0; f_free_tb = 1'b0;
    chk("mid_grant0", 64'(f_grant), 64'h0);
    chk("mid_pend0",  64'(f_pend),  64'h0);
    chk("mid_dn0",    64'(f_dn),    64'h0);
    chk("mid_free0",  64'(f_free),  64'h0);
    chk("mid_data0",  64'(f_odata), 64'h0);
    chk("mid_err0",   64'(f_err),   64'h0);
    tick();
    chk("mid_free1",  64'(f_free),  64'h0);
    chk("mid_idle",   64'(f_grant), 64'h0);
    f_drive = 4'b1000; f_data[3*DW +: DW] = 16'h7777;
    tick();
    f_drive = '0; f_data = '0;
    tick();
    chk("mid_new_g", 64'(f_grant), 64'h8);
    chk("mid_new_d", 64'(f_odata), 64'h7777);
    f_free_tb = 1'b1;
    tick();
    f_free_tb = 1'b0;
    chk("mid_new_f", 64'(f_free), 64'h8);

    // Round-robin: all ports always requesting, re-drive on o_free
    for (int p = 0; p < NP; p++) r_data[p*DW +: DW] = 16'(16'hC0 + p);
    r_drive = 4'b1111;
    tick();
    r_drive = '0;
    chk("rr_pend", 64'(r_pend), 64'hF);
    tick();
    for (int t = 0; t < 12; t++) begin
      eg = 4'b0001 << (t % 4);
      chk("rr_grant", 64'(r_grant), 64'(eg));
      chk("rr_data",  64'(r_odata), 64'(16'hC0 + (t % 4)));
      chk("rr_dn",    64'(r_dn),    64'h1);
      r_fnext = 1'b1;
      tick();
      r_fnext = 1'b0;
      chk("rr_free", 64'(r_free), 64'(eg));
      r_drive = r_free;
      tick();
      r_drive = '0;
    end
    chk("rr_pend_end", 64'(r_pend), 64'hF);
    chk("rr_err",      64'(r_err),  64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mutex_merge_n_sync.md
Name: mutex_merge_n_sync

Overview:
- Clocked, parametrised successor to the 4-port asynchronous mutex merge used in the MMU request path.
- Merges NUM_PORTS one-shot drive/free channels into a single downstream drive/free channel.
- Each port's request and data are captured in a per-port holding register. Ports that fire in the same cycle are arbitrated, fixed-priority or round-robin, instead of relying on mutual exclusion. Only one transaction is outstanding downstream at a time.

Parameters:
- NUM_PORTS, 4: number of upstream channels, 2..16.
- DATA_WIDTH, 128: payload width per channel.
- ARB_MODE, 0: 0 = fixed priority (port 0 highest); 1 = round-robin.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- i_drive  in  NUM_PORTS  per-port one-cycle request pulse.
- i_data  in  NUM_PORTS*DATA_WIDTH  port p payload in bits [p*DATA_WIDTH +: DATA_WIDTH]; sampled only on the cycle i_drive[p]=1.
- o_free  out  NUM_PORTS  per-port one-cycle completion pulse.
- o_driveNext  out  1  one-cycle downstream request pulse.
- o_data  out  DATA_WIDTH  downstream payload, registered.
- i_freeNext  in  1  downstream one-cycle completion pulse.
- o_grant  out  NUM_PORTS  one-hot owner of the outstanding transaction; 0 when idle.
- o_pending  out  NUM_PORTS  per-port captured-but-not-freed bits.
- o_err  out  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=1 at an edge):
  - State goes to IDLE.
  - pending, o_grant, o_free, o_driveNext, o_data, o_err and the rr pointer are all cleared to 0.
  - i_drive and i_freeNext in the reset cycle are ignored.
  - Reset mid-transaction abandons the transaction: no o_free is issued.
- Capture: at each edge with i_drive[p]=1 and pending[p]=0, set pending[p] and latch that port's i_data slice into hold[p].
- Drive while pending: if i_drive[p]=1 while pending[p]=1, the pulse is ignored and o_err is set.
- Arbitration: evaluated in IDLE over the registered pending vector.
  - Fixed mode: lowest index wins.
  - RR mode: search starts at the rr pointer, wrapping modulo NUM_PORTS.
- State machine: IDLE, WAIT.
  - IDLE with any pending bit set: the edge latches o_grant = winner, o_data = hold[winner], o_driveNext = 1, then state moves to WAIT.
  - WAIT: o_driveNext falls after exactly one cycle. o_grant and o_data stay stable until the transaction completes.
  - WAIT with i_freeNext=1, including the same cycle o_driveNext is high (zero-latency consumer):
    - pending[g] clears and o_free[g] pulses for one cycle.
    - o_grant clears and state returns to IDLE.
    - In RR mode, the pointer becomes (g+1) mod NUM_PORTS.
  - i_freeNext in IDLE is ignored and sets o_err.
- Latency (idle, sole request):
  - i_drive sampled at edge E0 → o_driveNext high E1..E2.
  - i_freeNext sampled at edge Ek → o_free high Ek..Ek+1.
  - Next grant is issued no earlier than edge Ek+1.
  - Minimum 2 cycles per transaction with a zero-latency consumer.
- Re-request: a port may drive again in the same cycle its o_free is high; pending was already cleared at that edge, so the request is accepted.
- A new request on a non-granted port during WAIT is captured and waits for IDLE.
- o_pending mirrors the pending register. o_data holds its last value while idle.

Decomposition:
- Package mutex_merge_pkg:
  - state enum {IDLE, WAIT}
  - constants ARB_FIXED=0, ARB_RR=1
  - a function clog2 for the pointer width
- Sub-module merge_arbiter:
  - Combinational pick from a pending vector plus pointer, selected by ARB_MODE.
  - Outputs a one-hot grant and the encoded index.
- Top level holds the per-port hold registers, pending, FSM, pointer and error logic.

Test Plan:
- Single request: port 2 drives with data 0xA5 → o_driveNext pulses at E1, o_data=0xA5, o_grant=4'b0100; freeNext 3 cycles later → o_free[2] pulses, pending=0.
- Simultaneous requests, fixed mode: ports 0,1,3 drive in the same cycle → grant order 0,1,3, each data delivered intact, three o_free pulses in that order.
- Simultaneous requests, RR mode: all 4 ports drive continuously (re-drive on o_free) for 12 transactions → grant sequence 0,1,2,3 repeated, no starvation.
- Zero-latency consumer: i_freeNext tied to o_driveNext → one transaction every 2 cycles, o_err stays 0.
- Protocol errors: port 1 drives twice before its free → second pulse ignored, o_err=1; stray i_freeNext while idle → o_err=1, no o_free.
- Mid-transaction reset: reset asserted during WAIT with 3 ports pending → all outputs 0 the next cycle; no o_free issued; a fresh request afterwards completes normally.
